// File: rtl/mac_operand_feeder.sv
// rtl/mac_operand_feeder.sv - operand-pair buffer and run sequencer feeding one MAC accumulator
// Optional MAC_FEEDER_STALL_EN adds a stall input that pauses pair issue during STREAM.
module mac_operand_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int PIPE_LAT   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [DATA_WIDTH-1:0]   load_a,
    input  logic [DATA_WIDTH-1:0]   load_b,
    input  logic                    start,
`ifdef MAC_FEEDER_STALL_EN
    input  logic                    stall,
`endif
    output logic                    busy,
    output logic                    mac_clr,
    output logic                    mac_en,
    output logic [DATA_WIDTH-1:0]   mac_a,
    output logic [DATA_WIDTH-1:0]   mac_b,
    input  logic [3*DATA_WIDTH-1:0] mac_cout,
    output logic [3*DATA_WIDTH-1:0] result,
    output logic                    result_valid
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int IW  = $clog2(DEPTH);
    localparam int DCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_STREAM,
        S_DRAIN,
        S_CAPTURE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [DATA_WIDTH-1:0]  buf_a [DEPTH];
    logic [DATA_WIDTH-1:0]  buf_b [DEPTH];
    logic [CW-1:0]          count;
    logic [IW-1:0]          idx;
    logic [DCW-1:0]         dcnt;
    logic                   stall_i;
    logic                   load_acc;
    logic                   issue;
    logic                   last_pair;
    logic                   drain_done;

`ifdef MAC_FEEDER_STALL_EN
    assign stall_i = stall;
`else
    assign stall_i = 1'b0;
`endif

    assign load_ready = (state == S_IDLE) && (count < CW'(DEPTH));
    assign load_acc   = load_valid && load_ready;
    assign issue      = (state == S_STREAM) && !stall_i;
    assign last_pair  = (CW'(idx) == (count - CW'(1)));
    assign drain_done = (dcnt == DCW'(PIPE_LAT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A pair accepted on the start edge counts toward a non-empty run.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start && ((count != '0) || load_acc)) state_nxt = S_CLR;
            S_CLR:     state_nxt = S_STREAM;
            S_STREAM:  if (issue && last_pair) state_nxt = S_DRAIN;
            S_DRAIN:   if (drain_done) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (load_acc) begin
            buf_a[count[IW-1:0]] <= load_a;
            buf_b[count[IW-1:0]] <= load_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            idx    <= '0;
            dcnt   <= '0;
            result <= '0;
        end else begin
            if (load_acc) count <= count + CW'(1);
            case (state)
                S_CLR: begin
                    idx  <= '0;
                    dcnt <= '0;
                end
                S_STREAM: if (issue) idx <= idx + IW'(1);
                S_DRAIN: begin
                    if (drain_done) begin
                        result <= mac_cout;
                        dcnt   <= '0;
                    end else begin
                        dcnt <= dcnt + DCW'(1);
                    end
                end
                S_CAPTURE: count <= '0;
                default: ;
            endcase
        end
    end

    // Operands stay on the bus through a stall so the MAC sees a stable pair.
    assign busy         = (state != S_IDLE);
    assign mac_clr      = (state == S_CLR);
    assign mac_en       = issue;
    assign mac_a        = (state == S_STREAM) ? buf_a[idx] : '0;
    assign mac_b        = (state == S_STREAM) ? buf_b[idx] : '0;
    assign result_valid = (state == S_CAPTURE);

endmodule
